// File: rtl/ibex_xif_csr_access_master.sv
// CSR access master: queues CSR requests in a small FIFO and issues them one
// at a time to the cs_registers CSR port, returning the old value and the
// illegal flag through a valid/ready response channel.
// Optional statistics counters are built when IBEX_XIF_CSR_ACCESS_STATS_EN is defined.
//
// state | meaning
// IDLE  | nothing outstanding, waiting for a request
// ISSUE | one-cycle CSR strobe with the popped command
// RESP  | response held until rsp_ready_i
module ibex_xif_csr_access_master #(
  parameter int unsigned ReqFifoDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [11:0] req_addr_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_wdata_i,
  output logic        csr_access_o,
  output logic        csr_op_en_o,
  output logic [11:0] csr_addr_o,
  output logic [1:0]  csr_op_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  input  logic        illegal_csr_insn_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o,
  output logic [15:0] issued_cnt_o,
  output logic [15:0] illegal_cnt_o
);

  localparam int unsigned PtrW = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(ReqFifoDepth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(ReqFifoDepth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(ReqFifoDepth - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  typedef struct packed {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
  } req_t;

  req_t            mem_q [ReqFifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [1:0]      state_q, state_d;
  req_t            cmd_q, cmd_d, req_in;
  logic            full, empty, push, fifo_push, pop, load_cmd;
  logic [31:0]     rdata_q;
  logic            illegal_q;

  assign req_in      = '{addr: req_addr_i, op: req_op_i, wdata: req_wdata_i};
  assign full        = (count_q == DepthCnt);
  assign empty       = (count_q == '0);
  assign req_ready_o = ~full;
  assign push        = req_valid_i & req_ready_o;

  // Next-state logic; an idle master with an empty FIFO takes the incoming
  // request straight into the command register so it issues next cycle.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_cmd  = 1'b0;
    cmd_d     = mem_q[rd_ptr_q];
    fifo_push = push;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          load_cmd = 1'b1;
          state_d  = ISSUE;
        end else if (push) begin
          fifo_push = 1'b0;
          load_cmd  = 1'b1;
          cmd_d     = req_in;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        if (rsp_ready_i) begin
          if (!empty) begin
            pop      = 1'b1;
            load_cmd = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clk_i) begin
    if (fifo_push) mem_q[wr_ptr_q] <= req_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)       rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      case ({fifo_push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state, command register and response capture at the end of ISSUE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_cmd) cmd_q <= cmd_d;
      if (state_q == ISSUE) begin
        rdata_q   <= csr_rdata_i;
        illegal_q <= illegal_csr_insn_i;
      end
    end
  end

  assign csr_access_o  = (state_q == ISSUE);
  assign csr_op_en_o   = (state_q == ISSUE);
  assign csr_addr_o    = (state_q == ISSUE) ? cmd_q.addr  : 12'h000;
  assign csr_op_o      = (state_q == ISSUE) ? cmd_q.op    : 2'd0;
  assign csr_wdata_o   = (state_q == ISSUE) ? cmd_q.wdata : 32'h0;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_illegal_o = illegal_q;

`ifdef IBEX_XIF_CSR_ACCESS_STATS_EN
  logic [15:0] issued_q, illegal_cnt_q;

  // Saturating statistics counters, sampled on every ISSUE cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q      <= '0;
      illegal_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      if (issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      if (illegal_csr_insn_i && (illegal_cnt_q != 16'hFFFF))
        illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end
  end

  assign issued_cnt_o  = issued_q;
  assign illegal_cnt_o = illegal_cnt_q;
`else
  assign issued_cnt_o  = 16'h0000;
  assign illegal_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ibex_xif_csr_access_master.sv
// Directed bench for ibex_xif_csr_access_master with a small CSR responder
// model (mscratch read/write, mhartid read-only, anything else illegal).
module tb_ibex_xif_csr_access_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [11:0] req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_wdata;
  logic        csr_access, csr_op_en;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_ill;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic [15:0] issued_cnt, illegal_cnt;

  int tests = 0;
  int fails = 0;
  int n_issued = 0;
  int n_illegal = 0;

  localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_SET = 2'd2, OP_CLEAR = 2'd3;

  ibex_xif_csr_access_master dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_addr_i         (req_addr),
    .req_op_i           (req_op),
    .req_wdata_i        (req_wdata),
    .csr_access_o       (csr_access),
    .csr_op_en_o        (csr_op_en),
    .csr_addr_o         (csr_addr),
    .csr_op_o           (csr_op),
    .csr_wdata_o        (csr_wdata),
    .csr_rdata_i        (csr_rdata),
    .illegal_csr_insn_i (csr_ill),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_rdata_o        (rsp_rdata),
    .rsp_illegal_o      (rsp_illegal),
    .issued_cnt_o       (issued_cnt),
    .illegal_cnt_o      (illegal_cnt)
  );

  always #5 clk = ~clk;

  // Responder model: returns the old value, updates on the strobe edge.
  logic [31:0] mscratch = 32'h0;
  always_comb begin
    csr_rdata = 32'h0;
    csr_ill   = 1'b1;
    if (csr_addr == 12'h340) begin
      csr_rdata = mscratch;
      csr_ill   = 1'b0;
    end else if (csr_addr == 12'hF14) begin
      csr_rdata = 32'h0;
      csr_ill   = (csr_op != OP_READ);
    end
  end

  always @(posedge clk) begin
    if (csr_op_en && !csr_ill && csr_addr == 12'h340) begin
      case (csr_op)
        OP_WRITE: mscratch <= csr_wdata;
        OP_SET:   mscratch <= mscratch | csr_wdata;
        OP_CLEAR: mscratch <= mscratch & ~csr_wdata;
        default:  mscratch <= mscratch;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string name);
`ifdef IBEX_XIF_CSR_ACCESS_STATS_EN
    chk({name, " issued_cnt"}, {16'h0, issued_cnt}, n_issued);
    chk({name, " illegal_cnt"}, {16'h0, illegal_cnt}, n_illegal);
`else
    chk({name, " issued_cnt"}, {16'h0, issued_cnt}, 32'h0);
    chk({name, " illegal_cnt"}, {16'h0, illegal_cnt}, 32'h0);
`endif
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    logic [31:0] held;
    logic [31:0] bp_data[4];
    int          strobes;

    vecs[0] = '{OP_WRITE, 12'h340, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1] = '{OP_READ,  12'h340, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{OP_SET,   12'h340, 32'h0000000F, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{OP_CLEAR, 12'h340, 32'h000000F0, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{OP_READ,  12'h340, 32'h00000000, 32'hDEADBE0F, 1'b0};
    vecs[5] = '{OP_WRITE, 12'hF14, 32'h00000001, 32'h00000000, 1'b1};
    vecs[6] = '{OP_READ,  12'hF14, 32'h00000000, 32'h00000000, 1'b0};
    bp_data[0] = 32'h22222222;
    bp_data[1] = 32'h33333333;
    bp_data[2] = 32'h44444444;
    bp_data[3] = 32'h55555555;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_op = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset req_ready", req_ready, 1);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset csr_access", csr_access, 0);
    chk("reset csr_addr", csr_addr, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_illegal", rsp_illegal, 0);
    chk_counters("reset");

    // Single transactions with exact latency: accept N, strobe N+1, response N+2.
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1; req_op = vecs[i].op; req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
      chk($sformatf("v%0d ready", i), req_ready, 1);
      chk($sformatf("v%0d no early strobe", i), csr_access, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk($sformatf("v%0d strobe", i), {csr_access, csr_op_en}, 2'b11);
      chk($sformatf("v%0d csr_op", i), csr_op, vecs[i].op);
      chk($sformatf("v%0d csr_addr", i), csr_addr, vecs[i].addr);
      chk($sformatf("v%0d csr_wdata", i), csr_wdata, vecs[i].wdata);
      chk($sformatf("v%0d rsp_valid early", i), rsp_valid, 0);
      n_issued++;
      if (vecs[i].exp_ill) n_illegal++;
      @(posedge clk); #1;
      chk($sformatf("v%0d strobe off", i), {csr_access, csr_op_en, csr_addr, csr_op, csr_wdata}, 0);
      chk($sformatf("v%0d rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d rsp_illegal", i), rsp_illegal, vecs[i].exp_ill);
      @(posedge clk); #1;
      chk($sformatf("v%0d rsp done", i), rsp_valid, 0);
    end
    chk_counters("after vectors");

    // Backpressure: one op parked in RESP, FIFO of 2 fills, rest refused.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = OP_WRITE; req_addr = 12'h340; req_wdata = 32'h11111111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_issued++;
    @(posedge clk); #1;
    chk("bp rsp_valid", rsp_valid, 1);
    chk("bp rsp_rdata A", rsp_rdata, 32'hDEADBE0F);
    held = rsp_rdata;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_wdata = bp_data[i];
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp accepted", acc, 2);
    chk("bp req_ready", req_ready, 0);
    for (int i = 0; i < 6; i++) begin
      chk("bp held valid", rsp_valid, 1);
      chk("bp held rdata", rsp_rdata, held);
      chk("bp no strobe", csr_access, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp issue B", {csr_access, csr_wdata}, {1'b1, 32'h22222222});
    n_issued++;
    @(posedge clk); #1;
    chk("bp rsp B", {rsp_valid, rsp_rdata}, {1'b1, 32'h11111111});
    @(posedge clk); #1;
    chk("bp issue C", {csr_access, csr_wdata}, {1'b1, 32'h33333333});
    n_issued++;
    @(posedge clk); #1;
    chk("bp rsp C", {rsp_valid, rsp_rdata}, {1'b1, 32'h22222222});
    @(posedge clk); #1;
    chk("bp drained", {rsp_valid, csr_access}, 2'b00);
    chk("bp ready again", req_ready, 1);
    chk_counters("after bp");

    // Reset in RESP with two requests queued.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = OP_WRITE; req_addr = 12'h340; req_wdata = 32'h66666666;
    @(posedge clk); #1;
    req_wdata = 32'h77777777;
    @(posedge clk); #1;
    req_wdata = 32'h88888888;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst pre rsp_valid", rsp_valid, 1);
    chk("rst pre req_ready", req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst req_ready", req_ready, 1);
    chk("rst csr_access", csr_access, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    n_issued = 0; n_illegal = 0;
    chk_counters("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    strobes = 0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (csr_access || csr_op_en) strobes++;
      if (rsp_valid) acc++;
    end
    chk("post-rst strobes", strobes, 0);
    chk("post-rst responses", acc, 0);
    chk("post-rst req_ready", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ibex_xif_csr_access_master.md
IBEX_XIF_CSR_ACCESS_MASTER -- requirements
Module: ibex_xif_csr_access_master

Interface
REQ-001 Parameter ReqFifoDepth, default 2, request FIFO entries (legal 2..8).
REQ-002 clk_i  in  1  single clock; all logic on rising edge.
REQ-003 rst_ni  in  1  asynchronous active-low reset.
REQ-004 req_valid_i  in  1  request present.
REQ-005 req_ready_o  out  1  request FIFO not full.
REQ-006 req_addr_i  in  12  CSR address (ibex_xif_pkg::csr_num_e encoding).
REQ-007 req_op_i  in  2  ibex_xif_pkg::csr_op_e (READ=0, WRITE=1, SET=2, CLEAR=3).
REQ-008 req_wdata_i  in  32  write/set/clear operand.
REQ-009 csr_access_o, csr_op_en_o  out  1 each  CSR strobe pair, to cs_registers csr_access_i/csr_op_en_i.
REQ-010 csr_addr_o 12, csr_op_o 2, csr_wdata_o 32  out  CSR command fields.
REQ-011 csr_rdata_i  in  32; illegal_csr_insn_i  in  1  responder results, combinational in strobe cycle.
REQ-012 rsp_valid_o  out  1; rsp_ready_i  in  1  response handshake.
REQ-013 rsp_rdata_o  out  32; rsp_illegal_o  out  1  captured results.
REQ-014 issued_cnt_o, illegal_cnt_o  out  16 each  statistics counters.

Function
REQ-015 Request accepted when req_valid_i & req_ready_o; entry {addr,op,wdata} pushed into FIFO in order.
REQ-016 req_ready_o SHALL equal !full, independent of same-cycle pop (no pass-through).
REQ-017 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE when FIFO non-empty (head popped).
REQ-018 ISSUE lasts exactly one cycle; csr_access_o=csr_op_en_o=1, fields = popped entry; ISSUE->RESP unconditionally.
REQ-019 Outside ISSUE: csr_access_o=0, csr_op_en_o=0, csr_addr_o=0, csr_op_o=READ, csr_wdata_o=0.
REQ-020 At end of ISSUE, csr_rdata_i and illegal_csr_insn_i captured into rsp_rdata_o/rsp_illegal_o.
REQ-021 RESP: rsp_valid_o=1, response stable until rsp_ready_i; on handshake ->ISSUE if FIFO non-empty, else IDLE.
REQ-022 Latency: request accepted in IDLE with empty FIFO at cycle N -> ISSUE at N+1 -> rsp_valid_o at N+2; back-to-back throughput one op per 2 cycles with rsp_ready_i=1.
REQ-023 Requests issued strictly in acceptance order; one outstanding CSR op max.
REQ-024 Illegal access still returns a response with rsp_illegal_o=1 and captured rdata; no retry.
REQ-025 FIFO pointers wrap modulo ReqFifoDepth; full/empty by occupancy count.

Reset
REQ-026 rst_ni low SHALL immediately clear FIFO, force IDLE, deassert req_ready_o? no: req_ready_o=1 after reset, rsp_valid_o=0, CSR outputs per REQ-019, rsp_rdata_o=0, rsp_illegal_o=0, counters=0.
REQ-027 Reset mid-ISSUE or mid-RESP discards operation and all queued requests; no response emitted.

Configuration
REQ-028 Macro IBEX_XIF_CSR_ACCESS_STATS_EN defined: issued_cnt_o increments each ISSUE cycle, illegal_cnt_o increments each ISSUE with illegal_csr_insn_i=1; both saturate at 0xFFFF.
REQ-029 Macro undefined: counter logic absent, issued_cnt_o and illegal_cnt_o tied 0; all other behaviour identical.

Verification
REQ-030 Reset, WRITE 0x340 (mscratch) data 0xDEADBEEF accepted cycle N -> csr_access_o/csr_op_en_o high only cycle N+1 with op=1; rsp_valid_o N+2, rsp_illegal_o=0.
REQ-031 READ 0x340 after REQ-030 -> rsp_rdata_o=0xDEADBEEF; SET 0x0000000F then CLEAR 0x000000F0 then READ -> rdata 0xDEADBE0F.
REQ-032 rsp_ready_i held low 10 cycles, 4 requests offered with ReqFifoDepth=2 -> exactly 2 accepted, req_ready_o=0, response held stable; release -> remaining ops issue in order.
REQ-033 WRITE to read-only 0xF14 (mhartid) -> rsp_illegal_o=1; with IBEX_XIF_CSR_ACCESS_STATS_EN illegal_cnt_o=1, issued_cnt_o=1; without, both 0.
REQ-034 rst_ni pulsed low during RESP with 2 queued -> rsp_valid_o drops same cycle, no further CSR strobes, req_ready_o=1 after release.
